// File: rtl/muxn_rr_if.sv
// ----------------------------------------------------------------------------
// muxn_rr_if: stream bundle between N producers and one consumer of muxn_rr
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface muxn_rr_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SELW = $clog2(N);

  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SELW-1:0] out_ch;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

`default_nettype wire

// File: rtl/muxn_rr.sv
// ----------------------------------------------------------------------------
// muxn_rr: N-channel registered stream mux, manual or round-robin selection
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module muxn_rr #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  wire logic clk,
  input  wire logic rst,
  muxn_rr_if.slave  bus
);
  localparam int SELW = $clog2(N);
  localparam logic [SELW-1:0] c_last = SELW'(N - 1);

  logic            load;
  logic            grant_valid;
  logic [SELW-1:0] grant;
  logic [W-1:0]    grant_data;
  logic [N-1:0]    in_ready;

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_ch_q,    out_ch_d;
  logic [SELW-1:0] ptr_q,       ptr_d;

  assign load = !out_valid_q || bus.out_ready;

  always_comb begin : grant_logic
    int idx;
    idx         = 0;
    grant       = '0;
    grant_valid = 1'b0;
    if (bus.mode) begin
      // Scan backwards so the last hit written is the first valid channel at/after ptr.
      for (int i = N - 1; i >= 0; i--) begin
        idx = int'(ptr_q) + i;
        if (idx >= N) idx = idx - N;
        if (bus.in_valid[idx]) begin
          grant_valid = 1'b1;
          grant       = SELW'(idx);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (int'(bus.sel) == k && bus.in_valid[k]) begin
          grant_valid = 1'b1;
          grant       = SELW'(k);
        end
      end
    end
  end

  always_comb begin : data_select
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(grant) == k) grant_data = bus.in_data[k*W +: W];
    end
  end

  always_comb begin : ready_decode
    in_ready = '0;
    for (int k = 0; k < N; k++) begin
      in_ready[k] = load && grant_valid && (int'(grant) == k) && !rst;
    end
  end

  always_comb begin : next_state
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data;
        out_ch_d    = grant;
        ptr_d       = (grant == c_last) ? '0 : grant + 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule

`default_nettype wire

// File: tb/tb_muxn_rr.sv
// ----------------------------------------------------------------------------
// tb_muxn_rr: vector table with a scoreboard of expected output words
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_muxn_rr;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  muxn_rr_if #(.N(4), .W(8)) bus ();

  muxn_rr #(.N(4), .W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       chk_zero;
  } vec_t;

  vec_t       vq[$];
  logic [9:0] sb[$];
  logic [7:0] chan_data [4];

  function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s,
                              input logic [3:0] v, input logic o,
                              input logic [3:0] e, input logic z);
    vec_t t;
    t.rst = r; t.mode = m; t.sel = s; t.valid = v;
    t.ordy = o; t.exp_rdy = e; t.chk_zero = z;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    int idx;
    @(negedge clk);
    rst           = v.rst;
    bus.mode      = v.mode;
    bus.sel       = v.sel;
    bus.in_valid  = v.valid;
    bus.out_ready = v.ordy;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(v.exp_rdy));
    if (sb.size() > 0) begin
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("out_data", 32'(bus.out_data), 32'(sb[0][7:0]));
      chk("out_ch", 32'(bus.out_ch), 32'(sb[0][9:8]));
      if (v.ordy) void'(sb.pop_front());
    end else begin
      chk("out_valid_idle", 32'(bus.out_valid), 32'd0);
    end
    if (v.chk_zero) begin
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
    end
    if (v.exp_rdy != 4'b0000) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (v.exp_rdy[k]) idx = k;
      sb.push_back({2'(idx), chan_data[idx]});
    end
    @(posedge clk);
    if (v.rst) sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt [4];
    n_tests = 0;
    n_fail  = 0;
    chan_data[0] = 8'h10; chan_data[1] = 8'h21;
    chan_data[2] = 8'h32; chan_data[3] = 8'h43;
    bus.in_data   = 32'h4332_2110;
    bus.in_valid  = 4'hF;
    bus.mode      = 1'b1;
    bus.sel       = 2'd0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    @(posedge clk);

    //            rst mode sel valid  ordy exp   zero
    // reset held with all channels requesting
    vq.push_back(mk(1, 1, 0, 4'hF, 1, 4'h0, 0));
    vq.push_back(mk(1, 1, 0, 4'hF, 1, 4'h0, 0));
    // manual sweep, then a select of a non-valid channel
    vq.push_back(mk(0, 0, 0, 4'hF, 1, 4'h1, 1));
    vq.push_back(mk(0, 0, 1, 4'hF, 1, 4'h2, 0));
    vq.push_back(mk(0, 0, 2, 4'hF, 1, 4'h4, 0));
    vq.push_back(mk(0, 0, 3, 4'hF, 1, 4'h8, 0));
    vq.push_back(mk(0, 0, 2, 4'hB, 1, 4'h0, 0));
    // round-robin fairness
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0, 1, 0, 4'hF, 1, 4'(1 << (i % 4)), 0));
    // sparse requests, then channel 3 dropped so the pointer wraps to 0
    vq.push_back(mk(0, 1, 0, 4'hA, 1, 4'h2, 0));
    vq.push_back(mk(0, 1, 0, 4'hA, 1, 4'h8, 0));
    vq.push_back(mk(0, 1, 0, 4'hA, 1, 4'h2, 0));
    vq.push_back(mk(0, 1, 0, 4'hA, 1, 4'h8, 0));
    vq.push_back(mk(0, 1, 0, 4'h2, 1, 4'h2, 0));
    // backpressure while holding 0x21 from channel 1
    vq.push_back(mk(0, 1, 0, 4'hF, 0, 4'h0, 0));
    vq.push_back(mk(0, 1, 0, 4'hF, 0, 4'h0, 0));
    vq.push_back(mk(0, 1, 0, 4'hF, 0, 4'h0, 0));
    vq.push_back(mk(0, 1, 0, 4'hF, 1, 4'h4, 0));
    vq.push_back(mk(0, 1, 0, 4'hF, 1, 4'h8, 0));
    // bring ptr to 2, then reset mid-stream
    vq.push_back(mk(0, 1, 0, 4'hF, 1, 4'h1, 0));
    vq.push_back(mk(0, 1, 0, 4'hF, 1, 4'h2, 0));
    vq.push_back(mk(1, 1, 0, 4'hF, 1, 4'h0, 0));
    vq.push_back(mk(0, 1, 0, 4'hF, 1, 4'h1, 1));
    vq.push_back(mk(0, 1, 0, 4'hF, 1, 4'h2, 0));
    // drain
    vq.push_back(mk(0, 1, 0, 4'h0, 1, 4'h0, 0));
    vq.push_back(mk(0, 1, 0, 4'h0, 1, 4'h0, 0));

    foreach (vq[i]) apply(vq[i]);

    // Fairness over 8 transfers from an arbitrary pointer: one-hot grants, two per channel.
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.mode      = 1'b1;
      bus.in_valid  = 4'hF;
      bus.out_ready = 1'b1;
      #1;
      chk("rr_onehot", 32'($onehot(bus.in_ready)), 32'd1);
      for (int k = 0; k < 4; k++) if (bus.in_ready[k]) cnt[k]++;
      @(posedge clk);
    end
    for (int k = 0; k < 4; k++) chk("rr_share", 32'(cnt[k]), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/muxn_rr.md
# muxn_rr

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It generalises the 4:1 single-bit select mux into a streaming block with two selection modes: manual (external `sel`) and round-robin over requesting channels. It sits between several producer streams and one consumer. Output is registered: one-cycle latency, full throughput.

## Interface
Parameters:
- `N`, default 4: number of input channels, N ≥ 2, need not be a power of 2.
- `W`, default 8: data width per channel.
- `SELW`, localparam, $clog2(N): select and channel-index width.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_data`  in  N*W  flattened channel data; channel k occupies `[k*W +: W]`.
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready; at most one bit set.
- `mode`  in  1  0 = manual select, 1 = round-robin.
- `sel`  in  SELW  channel index used in manual mode.
- `out_data`  out  W  registered selected data.
- `out_valid`  out  1  output valid.
- `out_ready`  in  1  consumer ready.
- `out_ch`  out  SELW  index of the channel that produced `out_data`.

## Operation
- Load enable: `load = !out_valid || out_ready`. This gives a pipelined accept, with no bubble under continuous flow.
- Grant, combinational:
  - Manual mode (`mode`=0): grant channel `sel` if `sel < N` and `in_valid[sel]`. Otherwise no grant. `sel ≥ N` never grants.
  - Round-robin mode (`mode`=1): scan from `ptr` upward with wrap N-1 → 0. Grant the first channel with `in_valid` set. No valid channel means no grant.
- `in_ready[k] = load && grant_valid && grant == k && !rst`. In-ready is one-hot or zero. A transfer occurs on `in_valid[k] && in_ready[k]`.
- On `load`:
  - With a grant: `out_data` ← channel data, `out_ch` ← grant, `out_valid` ← 1.
  - Without a grant: `out_valid` ← 0. `out_data` and `out_ch` hold.
- When `load` is false: all output registers hold. A stalled output must not change `out_data` or `out_ch`.
- `ptr` (SELW bits, internal) updates on every input transfer in either mode to `(grant+1)` mod N, wrapping N-1 → 0 explicitly. It is unchanged with no transfer.
- `mode` and `sel` are sampled combinationally each cycle. Switching them mid-stream is legal; the value already in the output register is unaffected.
- Reset, synchronous:
  - Cycle after `rst` high: `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0.
  - While `rst` is high: `in_ready`=0, so no transfer occurs. This holds even if reset asserts mid-stream; a pending output word is dropped.

## Timing
- Latency: an input transfer at edge t makes `out_valid`=1 with that data after edge t. The word is visible during cycle t+1.
- Throughput: one word per cycle while `out_ready`=1 and a grant exists.
- Backpressure: with `out_valid`=1 and `out_ready`=0, `in_ready` is all zero and the outputs are stable.
- Simultaneous events: with `out_valid`=1 and `out_ready`=1 in the same cycle, the output word is consumed and the next granted word is loaded on the same edge.
- Fairness in round-robin mode: with all N channels continuously valid, each channel is granted exactly once per N consecutive transfers.
- No combinational path from `out_ready` to `out_data`. The path `out_ready` → `in_ready` is combinational and permitted.

## Test plan
All scenarios use N=4, W=8.
- Reset: hold `rst`=1 for 2 cycles with all `in_valid`=1. Required: `in_ready`=0000, `out_valid`=0, `out_data`=0x00, `out_ch`=0, and no transfer.
- Manual sweep: `mode`=0, channel data 0x10/0x21/0x32/0x43, all valid, `out_ready`=1, `sel` stepped 0..3, one per cycle. Required: `out_data` is 0x10, 0x21, 0x32, 0x43 one cycle after each `sel` value, with `out_ch` matching. A manual select of a non-valid channel yields `out_valid`=0 on the next cycle.
- Round-robin fairness: `mode`=1, all valid, `out_ready`=1 for 8 cycles. Required: `out_ch` sequence 0,1,2,3,0,1,2,3, and `in_ready` one-hot rotating.
- Sparse requests plus wrap: `mode`=1, only channels 1 and 3 valid. Required: `out_ch` alternates 1,3,1,3. Then drop channel 3 after granting it: the pointer wraps to 0, channel 1 is granted, and `out_ch`=1.
- Backpressure: `mode`=1, all valid, deassert `out_ready` for 3 cycles mid-stream while the output holds word 0x21 from channel 1. Required: `out_data`=0x21 and `out_ch`=1 stable, `in_ready`=0000. On release, `out_ch`=2 follows with no bubble.
- Reset mid-stream: in round-robin mode with `ptr`=2, assert `rst` for 1 cycle. Required: `out_valid`=0 and `ptr`=0 on the next cycle. With all valid, the first grant after release is channel 0.
